// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: captures one EX/MEM entry, runs a lane-aligned data-memory access with an ack timeout.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN traps misaligned half/word/double accesses without touching memory.
module mem_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          mem_ctl,
  input  logic [1:0]          wb_ctl,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W-1:0]   branch_addr,
  input  logic                zero,
  input  logic [4:0]          rd,
  output logic                dm_req,
  output logic                dm_we,
  output logic [DATA_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W/8-1:0] dm_be,
  input  logic                dm_ack,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic                out_valid,
  output logic [1:0]          wb_out,
  output logic [DATA_W-1:0]   alu_res_out,
  output logic [DATA_W-1:0]   read_data,
  output logic [4:0]          rd_out,
  output logic                branch_taken,
  output logic [DATA_W-1:0]   branch_addr_out,
  output logic                bus_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_branch, r_read, r_write, r_unsigned, r_zero;
  logic [1:0]          r_size, r_wb;
  logic [4:0]          r_rd;
  logic [7:0]          r_wait;
  logic [DATA_W-1:0]   r_alu, r_wdata, r_baddr, r_read_data;
  logic                r_bus_err, r_branch_taken;

  logic                w_accept, w_in_mem, w_misalign, w_timeout, w_sign;
  logic [3:0]          w_nbytes;
  logic [OFF_W-1:0]    w_off;
  logic [BYTES-1:0]    w_be;
  logic [DATA_W-1:0]   w_wdata, w_shift, w_load;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return (DATA_W == 64) ? 4'd8 : 4'd4;
    endcase
  endfunction

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_in_mem  = mem_ctl[4] | mem_ctl[3];
  assign w_timeout = (r_state == S_ACCESS) && !dm_ack && (r_wait == 8'(MAX_WAIT - 1));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic [3:0] w_in_nbytes;
  always_comb begin
    w_in_nbytes = size_bytes(mem_ctl[1:0]);
    w_misalign  = 1'b0;
    if (w_in_mem && (mem_ctl[1:0] != 2'b00))
      w_misalign = (alu_res[OFF_W-1:0] & OFF_W'(w_in_nbytes - 4'd1)) != '0;
  end
`else
  assign w_misalign = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (w_in_mem && !w_misalign) ? S_ACCESS : S_DONE;
      S_ACCESS: if (dm_ack || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // A full-bus-width access has no sub-word lane choice, so its offset is ignored.
  always_comb begin
    w_nbytes = size_bytes(r_size);
    w_off    = (int'(w_nbytes) >= BYTES) ? '0 : r_alu[OFF_W-1:0];
    w_wdata  = r_wdata << {w_off, 3'b000};
    w_shift  = dm_rdata >> {w_off, 3'b000};
    w_sign   = 1'b0;
    w_be     = '0;
    w_load   = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_nbytes));
      if (i == int'(w_nbytes) - 1) w_sign = w_shift[8*i+7];
    end
    for (int i = 0; i < BYTES; i++)
      w_load[8*i +: 8] = (i < int'(w_nbytes)) ? w_shift[8*i +: 8] : {8{w_sign & ~r_unsigned}};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_branch       <= 1'b0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_unsigned     <= 1'b0;
      r_zero         <= 1'b0;
      r_size         <= '0;
      r_wb           <= '0;
      r_rd           <= '0;
      r_wait         <= '0;
      r_alu          <= '0;
      r_wdata        <= '0;
      r_baddr        <= '0;
      r_read_data    <= '0;
      r_bus_err      <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_branch    <= mem_ctl[5];
        r_read      <= mem_ctl[4];
        r_write     <= mem_ctl[3];
        r_unsigned  <= mem_ctl[2];
        r_size      <= mem_ctl[1:0];
        r_wb        <= wb_ctl;
        r_alu       <= alu_res;
        r_wdata     <= write_data;
        r_baddr     <= branch_addr;
        r_zero      <= zero;
        r_rd        <= rd;
        r_wait      <= '0;
        r_read_data <= '0;
        r_bus_err   <= w_misalign;
        if (!(w_in_mem && !w_misalign)) r_branch_taken <= zero & mem_ctl[5];
      end else if (r_state == S_ACCESS) begin
        r_wait <= r_wait + 8'd1;
        if (dm_ack) begin
          r_read_data    <= (r_read && !r_write) ? w_load : '0;
          r_branch_taken <= r_zero & r_branch;
        end else if (w_timeout) begin
          r_bus_err      <= 1'b1;
          r_branch_taken <= r_zero & r_branch;
        end
      end
    end
  end

  assign in_ready        = (r_state == S_IDLE);
  assign dm_req          = (r_state == S_ACCESS);
  assign dm_we           = dm_req & r_write;
  assign dm_addr         = dm_req ? {r_alu[DATA_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dm_be           = dm_req ? w_be : '0;
  assign dm_wdata        = (dm_req && r_write) ? w_wdata : '0;
  assign out_valid       = (r_state == S_DONE);
  assign wb_out          = r_wb;
  assign alu_res_out     = r_alu;
  assign read_data       = r_read_data;
  assign rd_out          = r_rd;
  assign branch_taken    = r_branch_taken;
  assign branch_addr_out = r_baddr;
  assign bus_err         = r_bus_err;
endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath width; only 32 or 64 is legal.
REQ-002 The block SHALL have parameter MAX_WAIT, default 15, giving the data-memory ack timeout in cycles (1..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  EX/MEM entry valid.
- in_ready  out  1  stage can accept an entry.
- mem_ctl  in  6  {branch, read, write, unsigned, size[1:0]}.
- wb_ctl  in  2  writeback control.
- alu_res  in  DATA_W  address or ALU result.
- write_data  in  DATA_W  store data.
- branch_addr  in  DATA_W  branch target.
- zero  in  1  ALU zero flag.
- rd  in  5  destination register.
- dm_req  out  1  memory request.
- dm_we  out  1  write strobe.
- dm_addr  out  DATA_W  word-aligned address.
- dm_wdata  out  DATA_W  lane-shifted store data.
- dm_be  out  DATA_W/8  byte enables.
- dm_ack  in  1  memory done.
- dm_rdata  in  DATA_W  memory read data.
- out_valid  out  1  one-cycle MEM/WB valid pulse.
- wb_out  out  2  registered wb_ctl.
- alu_res_out  out  DATA_W  registered alu_res.
- read_data  out  DATA_W  extracted, extended load data.
- rd_out  out  5  registered rd.
- branch_taken  out  1  zero AND branch.
- branch_addr_out  out  DATA_W  registered branch_addr.
- bus_err  out  1  timeout flag, valid with out_valid.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE, with in_ready = (state == IDLE).
REQ-005 In IDLE, on in_valid && in_ready the block SHALL capture all inputs; it SHALL go to ACCESS if read or write is set, else to DONE.
REQ-006 In ACCESS the block SHALL hold dm_req high with stable dm_addr, dm_we, dm_be and dm_wdata until dm_ack is sampled high, then go to DONE.
REQ-007 In DONE the block SHALL assert out_valid for exactly one cycle and return to IDLE; latency is 2 cycles for a non-memory op and ack cycle + 1 for a memory op.
REQ-008 Sizes SHALL be 00 byte, 01 half, 10 word and 11 double; double is legal only when DATA_W = 64 and is treated as word otherwise.
- dm_addr SHALL be alu_res with its low log2(DATA_W/8) bits cleared.
- dm_be SHALL select the addressed lanes.
- write_data SHALL be shifted into those lanes.
REQ-009 Loads SHALL right-align the addressed lanes; they SHALL sign-extend unless unsigned = 1, in which case they zero-extend; non-loads SHALL produce read_data = 0.
REQ-010 Read and write both set SHALL be treated as a write.
REQ-011 branch_taken SHALL equal the captured zero AND branch, updated with out_valid.
REQ-012 A wait counter SHALL count ACCESS cycles; if MAX_WAIT cycles elapse without dm_ack the block SHALL drop dm_req, go to DONE and set bus_err = 1 with read_data = 0.
REQ-013 dm_ack SHALL be ignored outside ACCESS.

Reset
REQ-014 While rst_n is low the FSM SHALL enter IDLE asynchronously and all outputs and registers SHALL be 0 except in_ready = 1.
REQ-015 Reset asserted during ACCESS SHALL drop dm_req immediately, and the in-flight op SHALL produce no out_valid.

Configuration
REQ-016 With MEM_STAGE_MISALIGN_TRAP_EN defined, a half, word or double access whose alu_res is not size-aligned SHALL skip ACCESS (no dm_req) and go straight to DONE with bus_err = 1.
REQ-017 Without MEM_STAGE_MISALIGN_TRAP_EN, the low address bits SHALL select lanes as-is, and lanes beyond DATA_W SHALL be dropped.

Verification
REQ-018 Load byte, DATA_W = 32, alu_res = 0x103, dm_rdata = 0x80FFFFFF, ack 1 cycle after req -> dm_be = 1000, read_data = 0xFFFFFF80, out_valid 1 cycle after ack.
REQ-019 Store half at 0x202 with write_data = 0x1234 -> dm_addr = 0x200, dm_be = 1100, dm_wdata = 0x12340000, dm_we = 1.
REQ-020 No dm_ack for 15 cycles -> dm_req falls after 15 cycles, then out_valid = 1 with bus_err = 1.
REQ-021 Branch op with zero = 1 and no memory access -> out_valid and branch_taken = 1 two cycles after accept, with no dm_req.
REQ-022 rst_n pulsed low mid-ACCESS -> dm_req = 0 immediately, no out_valid, in_ready = 1 after release.
REQ-023 With MEM_STAGE_MISALIGN_TRAP_EN, load word at 0x101 -> no dm_req and bus_err = 1; without the macro -> dm_req with dm_be = 1111.
